cla_nibble_subtractor: RTL

Multi-cycle W-bit two's-complement subtractor, W = 4*NIBBLES. It computes diff = a - b - bin one 4-bit nibble per clock, LSB nibble first. Each nibble uses a 4-bit carry-lookahead slice on operands a and ~b. The borrow is carried between nibbles in a register. The block is the subtract-side companion of the team's 4-bit CLA adder and serves datapaths that need wide subtraction with little area. Input and output use valid/ready handshakes.

---
 rtl/cla_nibble_subtractor.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cla_nibble_subtractor.sv
// Multi-cycle W-bit subtractor: one 4-bit carry-lookahead slice computes a + ~b + ~bin,
// one nibble per clock, LSB first, with the inter-nibble carry held in a register.
module cla_nibble_subtractor #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 bin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] diff,
  output logic                 bout,
  output logic                 ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = $clog2(NIBBLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q, part_q, part_nxt;
  logic            c_q;
  logic [KW-1:0]   k_q;
  logic            accept, last;
  logic [3:0]      x, y;
  logic [4:0]      slice;

  // Returns {c4, s[3:0]} for x + y + ci with all carries flattened (no ripple).
  function automatic logic [4:0] cla4(input logic [3:0] xv, input logic [3:0] yv,
                                      input logic ci);
    logic [3:0] g, p;
    logic [4:0] c;
    g    = xv & yv;
    p    = xv ^ yv;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        accept = in_valid;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        last = (k_q == KW'(NIBBLES - 1));
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Nibble select and partial-result merge for the current slice index k.
  always_comb begin
    x        = '0;
    y        = '0;
    part_nxt = part_q;
    for (int n = 0; n < NIBBLES; n++) begin
      if (k_q == KW'(n)) begin
        x = a_q[4*n +: 4];
        y = ~b_q[4*n +: 4];
      end
    end
    slice = cla4(x, y, c_q);
    for (int n = 0; n < NIBBLES; n++) begin
      if (k_q == KW'(n)) part_nxt[4*n +: 4] = slice[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      k_q    <= '0;
      part_q <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      c_q    <= ~bin;
      k_q    <= '0;
      part_q <= '0;
    end else if (state == RUN) begin
      part_q <= part_nxt;
      c_q    <= slice[4];
      k_q    <= k_q + KW'(1);
      if (last) begin
        diff <= part_nxt;
        bout <= ~slice[4];
        ovf  <= (a_q[W-1] != b_q[W-1]) && (part_nxt[W-1] != a_q[W-1]);
      end
    end
  end

endmodule
